// File: rtl/prince_share_unloader_if.sv
// Host-side bus of the masked PRINCE share unloader: parallel share capture
// on the load side, CHUNK-per-share beats with valid/ready on the stream side.
interface prince_share_unloader_if #(
    parameter int SHARES = 2,
    parameter int CHUNK  = 8
);
    logic                    load;
    logic [64*SHARES-1:0]    din;
    logic                    busy;
    logic [CHUNK*SHARES-1:0] dout;
    logic                    dout_valid;
    logic                    dout_ready;
    logic                    dout_last;
    logic                    done;

    modport slave (
        input  load, din, dout_ready,
        output busy, dout, dout_valid, dout_last, done
    );

    modport master (
        output load, din, dout_ready,
        input  busy, dout, dout_valid, dout_last, done
    );
endinterface

// File: rtl/prince_share_unloader.sv
// Captures SHARES masked 64-bit shares in one cycle and streams them out
// MSB-first as CHUNK-bit slices per share; shares never share logic.
module prince_share_unloader #(
    parameter int SHARES = 2,
    parameter int CHUNK  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    prince_share_unloader_if.slave   bus
);
    localparam int NBEATS = 64 / CHUNK;
    localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    // One-hot so busy/dout_valid come straight off a flop bit.
    typedef enum logic [1:0] {
        IDLE   = 2'b01,
        STREAM = 2'b10
    } state_t;

    state_t                  state_q, state_d;
    logic [SHARES-1:0][63:0] sh_q, sh_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    last_q, last_d;
    logic                    done_q, done_d;
    logic                    xfer;

    assign xfer = state_q[1] & bus.dout_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.load) begin
                    sh_d    = bus.din;
                    cnt_d   = '0;
                    last_d  = (NBEATS == 1);
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (xfer) begin
                    if (last_q) begin
                        // Zeroize so no share residue lingers after the stream.
                        sh_d    = '0;
                        cnt_d   = '0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        for (int i = 0; i < SHARES; i++)
                            sh_d[i] = sh_q[i] << CHUNK;
                        cnt_d  = cnt_q + CW'(1);
                        last_d = ((cnt_q + CW'(1)) == CW'(NBEATS - 1));
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy       = state_q[1];
    assign bus.dout_valid = state_q[1];
    assign bus.dout_last  = last_q;
    assign bus.done       = done_q;

    for (genvar i = 0; i < SHARES; i++) begin : g_slice
        assign bus.dout[CHUNK*i +: CHUNK] = sh_q[i][63 -: CHUNK];
    end
endmodule

// File: tb/tb_prince_share_unloader.sv
// Scoreboarded bench: stimulus queues expected beats, negedge monitors pop
// and compare on every transfer and track the done pulse.
module tb_prince_share_unloader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prince_share_unloader_if #(.SHARES(2), .CHUNK(8)) b0 ();
    prince_share_unloader_if #(.SHARES(3), .CHUNK(4)) b1 ();

    prince_share_unloader #(.SHARES(2), .CHUNK(8)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
    prince_share_unloader #(.SHARES(3), .CHUNK(4)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));

    int checks   = 0;
    int failures = 0;

    logic [16:0] q0[$];
    logic [12:0] q1[$];
    logic        fin0 = 1'b0, fin1 = 1'b0, hv0 = 1'b0;
    logic [16:0] hd0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic miss(input string nm);
        checks++;
        failures++;
        $display("FAIL %s", nm);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push0(input logic [63:0] s0, input logic [63:0] s1, input int nb);
        for (int k = 0; k < nb; k++)
            q0.push_back({k == 7, s1[63-8*k -: 8], s0[63-8*k -: 8]});
    endtask

    task automatic wait_done0();
        int n = 0;
        while (!b0.done && n < 100) begin
            cyc();
            n++;
        end
        if (!b0.done) miss("u0 done timeout");
    endtask

    // Monitor for the 2-share / 8-bit instance.
    always @(negedge clk) begin
        if (b0.dout_valid && hv0) chk("u0 stall hold", {b0.dout_last, b0.dout}, hd0);
        hv0 = b0.dout_valid && !b0.dout_ready;
        hd0 = {b0.dout_last, b0.dout};
        if (b0.dout_valid && b0.dout_ready) begin
            if (q0.size() == 0) miss("u0 unexpected beat");
            else chk("u0 beat", {b0.dout_last, b0.dout}, q0.pop_front());
        end
        if (fin0 || b0.done) begin
            chk("u0 done pulse", b0.done, fin0);
            if (b0.done) chk("u0 busy at done", b0.busy, 0);
        end
        fin0 = b0.dout_valid && b0.dout_ready && b0.dout_last;
    end

    // Monitor for the 3-share / 4-bit instance.
    always @(negedge clk) begin
        if (b1.dout_valid && b1.dout_ready) begin
            if (q1.size() == 0) miss("u1 unexpected beat");
            else chk("u1 beat", {b1.dout_last, b1.dout}, q1.pop_front());
        end
        if (fin1 || b1.done) chk("u1 done pulse", b1.done, fin1);
        fin1 = b1.dout_valid && b1.dout_ready && b1.dout_last;
    end

    logic [16:0] basic_tab [8] = '{17'h0FE01, 17'h0DC23, 17'h0BA45, 17'h09867,
                                   17'h07689, 17'h054AB, 17'h032CD, 17'h110EF};
    localparam logic [63:0] S0 = 64'h0123456789ABCDEF;
    localparam logic [63:0] S1 = 64'hFEDCBA9876543210;

    initial begin
        logic [63:0] r0, r1, r2;
        b0.load = 1'b0; b0.din = '0; b0.dout_ready = 1'b0;
        b1.load = 1'b0; b1.din = '0; b1.dout_ready = 1'b0;

        // Reset held for two cycles.
        cyc(); cyc();
        chk("rst busy", b0.busy, 0);
        chk("rst valid", b0.dout_valid, 0);
        chk("rst last", b0.dout_last, 0);
        chk("rst done", b0.done, 0);
        chk("rst dout", b0.dout, 0);
        chk("rst u1 dout", {b1.busy, b1.dout_valid, b1.dout_last, b1.done, b1.dout}, 0);
        rst = 1'b0;

        // Basic stream with hand-computed beats.
        foreach (basic_tab[k]) q0.push_back(basic_tab[k]);
        b0.din = {S1, S0}; b0.load = 1'b1; b0.dout_ready = 1'b1;
        cyc();
        b0.load = 1'b0;
        chk("first beat valid", b0.dout_valid, 1);
        chk("busy after load", b0.busy, 1);
        wait_done0();
        chk("basic drained", q0.size(), 0);
        cyc();

        // Backpressure: ready pattern 1,0,0,1 repeating.
        push0(S0, S1, 8);
        b0.din = {S1, S0}; b0.load = 1'b1;
        cyc();
        b0.load = 1'b0;
        begin
            int n = 0;
            while (!b0.done && n < 200) begin
                b0.dout_ready = (n % 4 == 0) || (n % 4 == 3);
                cyc();
                n++;
            end
            if (!b0.done) miss("bp done timeout");
        end
        chk("bp drained", q0.size(), 0);
        b0.dout_ready = 1'b1;
        cyc();

        // Loads during beats 3 and 8 are ignored; load in the done cycle is taken.
        push0(S0, S1, 8);
        b0.din = {S1, S0}; b0.load = 1'b1;
        cyc();
        for (int c = 1; c <= 8; c++) begin
            cyc();
            if (c == 8) begin
                chk("done before reload", b0.done, 1);
                push0(64'h1122334455667788, 64'h99AABBCCDDEEFF00, 8);
                b0.din  = {64'h99AABBCCDDEEFF00, 64'h1122334455667788};
                b0.load = 1'b1;
            end else begin
                b0.din  = {64'hDEADBEEFDEADBEEF, 64'hCAFEF00DCAFEF00D};
                b0.load = (c == 2) || (c == 7);
            end
        end
        cyc();
        b0.load = 1'b0;
        chk("reload first beat", b0.dout_valid, 1);
        wait_done0();
        chk("reload drained", q0.size(), 0);
        cyc();

        // Reset after beat 4 aborts the stream.
        push0(64'h0F0F0F0F0F0F0F0F, 64'hA5A5A5A5A5A5A5A5, 4);
        b0.din = {64'hA5A5A5A5A5A5A5A5, 64'h0F0F0F0F0F0F0F0F}; b0.load = 1'b1;
        cyc();
        b0.load = 1'b0;
        for (int c = 1; c <= 4; c++) cyc();
        b0.dout_ready = 1'b0;
        rst = 1'b1;
        cyc();
        chk("abort outputs", {b0.busy, b0.dout_valid, b0.dout_last, b0.done, b0.dout}, 0);
        chk("abort shares", u0.sh_q, 0);
        chk("abort counter", u0.cnt_q, 0);
        rst = 1'b0;
        cyc();
        chk("abort no done", b0.done, 0);
        chk("abort drained", q0.size(), 0);

        // Zeroization: after a full stream, ready in IDLE exposes nothing.
        push0(S1, S0, 8);
        b0.din = {S0, S1}; b0.load = 1'b1; b0.dout_ready = 1'b1;
        cyc();
        b0.load = 1'b0;
        wait_done0();
        chk("zero drained", q0.size(), 0);
        for (int c = 0; c < 3; c++) begin
            cyc();
            chk("idle dout", b0.dout, 0);
            chk("idle valid", b0.dout_valid, 0);
        end
        chk("idle shares", u0.sh_q, 0);

        // CHUNK=4, SHARES=3 with random shares.
        r0 = {$urandom, $urandom}; r1 = {$urandom, $urandom}; r2 = {$urandom, $urandom};
        for (int k = 0; k < 16; k++)
            q1.push_back({k == 15, r2[63-4*k -: 4], r1[63-4*k -: 4], r0[63-4*k -: 4]});
        b1.din = {r2, r1, r0}; b1.load = 1'b1; b1.dout_ready = 1'b1;
        cyc();
        b1.load = 1'b0;
        begin
            int n = 0;
            while (!b1.done && n < 100) begin
                cyc();
                n++;
            end
            if (!b1.done) miss("u1 done timeout");
        end
        chk("u1 drained", q1.size(), 0);
        cyc();
        chk("u1 idle dout", b1.dout, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
